// File: rtl/spi_target.sv
// SPI mode-3 target: decodes 40-bit {wr, addr, data} frames into a local register file and
// answers each frame with {status, word selected by the previous frame}.
`timescale 1ns/1ps
module spi_target #(
    parameter int NUM_REGS   = 8,
    parameter int FRAME_BITS = 40
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     sck_in,
    input  logic                     cs_n_in,
    input  logic                     serial_in,
    output logic                     serial_out,
    output logic                     serial_oe,
    input  logic [7:0]               status_in,
    output logic                     frame_valid,
    output logic                     frame_write,
    output logic [6:0]               frame_addr,
    output logic [31:0]              frame_data,
    output logic                     frame_error,
    output logic [NUM_REGS*32-1:0]   regs_out
);

    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
    localparam logic [5:0] FULL_CNT   = 6'(FRAME_BITS);
    localparam logic [5:0] SAT_CNT    = 6'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state_reg, state_next;

    // Sync chains reset to the bus idle levels so releasing reset never fakes an edge.
    logic [1:0] sck_sync_reg, cs_sync_reg, mosi_sync_reg;
    logic       sck_d_reg, cs_d_reg;

    logic [FRAME_BITS-1:0] tx_shift_reg, rx_shift_reg;
    logic [5:0]            bit_cnt_reg;
    logic                  skip_fall_reg;
    logic [31:0]           pending_reg;
    logic [31:0]           reg_file_reg [NUM_REGS];
    logic                  serial_out_reg, serial_oe_reg;
    logic                  frame_valid_reg, frame_write_reg, frame_error_reg;
    logic [6:0]            frame_addr_reg;
    logic [31:0]           frame_data_reg;

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi;
    logic start, rx_step, fall_seen, finish, abort, commit;
    logic             rx_write, addr_ok;
    logic [6:0]       rx_addr;
    logic [31:0]      rx_data;
    logic [IDX_W-1:0] addr_idx;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sck_sync_reg  <= 2'b11;
            cs_sync_reg   <= 2'b11;
            mosi_sync_reg <= 2'b00;
            sck_d_reg     <= 1'b1;
            cs_d_reg      <= 1'b1;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[0], sck_in};
            cs_sync_reg   <= {cs_sync_reg[0], cs_n_in};
            mosi_sync_reg <= {mosi_sync_reg[0], serial_in};
            sck_d_reg     <= sck_sync_reg[1];
            cs_d_reg      <= cs_sync_reg[1];
        end
    end

    assign sck_rise = sck_sync_reg[1] & ~sck_d_reg;
    assign sck_fall = ~sck_sync_reg[1] & sck_d_reg;
    assign cs_rise  = cs_sync_reg[1] & ~cs_d_reg;
    assign cs_fall  = ~cs_sync_reg[1] & cs_d_reg;
    assign mosi     = mosi_sync_reg[1];

    always_ff @(posedge clk_in) begin
        if (reset_in) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // SCK edges are only acted on in SHIFT, so a CS edge always takes priority.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        rx_step    = 1'b0;
        fall_seen  = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    finish = 1'b1;
                    if (bit_cnt_reg == FULL_CNT) begin
                        state_next = COMMIT;
                    end else begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    rx_step   = sck_rise;
                    fall_seen = sck_fall;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_write = rx_shift_reg[FRAME_BITS-1];
    assign rx_addr  = rx_shift_reg[FRAME_BITS-2 -: 7];
    assign rx_data  = rx_shift_reg[31:0];
    assign addr_ok  = {1'b0, rx_addr} < NUM_REGS_W;
    assign addr_idx = rx_addr[IDX_W-1:0];

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            tx_shift_reg    <= '0;
            rx_shift_reg    <= '0;
            bit_cnt_reg     <= '0;
            skip_fall_reg   <= 1'b0;
            pending_reg     <= '0;
            serial_out_reg  <= 1'b0;
            serial_oe_reg   <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_write_reg <= 1'b0;
            frame_error_reg <= 1'b0;
            frame_addr_reg  <= '0;
            frame_data_reg  <= '0;
            for (int k = 0; k < NUM_REGS; k++) reg_file_reg[k] <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            frame_error_reg <= 1'b0;
            if (start) begin
                tx_shift_reg   <= {status_in, pending_reg};
                serial_out_reg <= status_in[7];
                serial_oe_reg  <= 1'b1;
                bit_cnt_reg    <= '0;
                skip_fall_reg  <= 1'b1;
            end
            if (rx_step) begin
                if (bit_cnt_reg < FULL_CNT) rx_shift_reg <= {rx_shift_reg[FRAME_BITS-2:0], mosi};
                if (bit_cnt_reg != SAT_CNT) bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
            // The MSB is already on the wire from CS fall, so the first SCK fall is skipped.
            if (fall_seen) begin
                if (skip_fall_reg) begin
                    skip_fall_reg <= 1'b0;
                end else begin
                    tx_shift_reg   <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
                    serial_out_reg <= tx_shift_reg[FRAME_BITS-2];
                end
            end
            if (finish) begin
                serial_oe_reg  <= 1'b0;
                serial_out_reg <= 1'b0;
            end
            if (abort) frame_error_reg <= 1'b1;
            if (commit) begin
                frame_valid_reg <= 1'b1;
                frame_write_reg <= rx_write;
                frame_addr_reg  <= rx_addr;
                frame_data_reg  <= rx_data;
                if (rx_write && addr_ok) reg_file_reg[addr_idx] <= rx_data;
                if (!addr_ok)      pending_reg <= '0;
                else if (rx_write) pending_reg <= rx_data;
                else               pending_reg <= reg_file_reg[addr_idx];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_out[gi*32 +: 32] = reg_file_reg[gi];
        end
    endgenerate

    assign serial_out  = serial_out_reg;
    assign serial_oe   = serial_oe_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_write = frame_write_reg;
    assign frame_addr  = frame_addr_reg;
    assign frame_data  = frame_data_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a mode-3 SPI master task drives frames and queues expectations,
// a monitor checks every frame_valid / frame_error pulse against the queue.
`timescale 1ns/1ps
module tb_spi_target;

    localparam int NREGS = 8;
    localparam int RW    = NREGS * 32;
    localparam int HALF  = 6;
    localparam int GAP   = 14;

    logic clk_in = 1'b0;
    logic reset_in, sck_in, cs_n_in, serial_in;
    logic serial_out, serial_oe;
    logic [7:0] status_in;
    logic frame_valid, frame_write, frame_error;
    logic [6:0] frame_addr;
    logic [31:0] frame_data;
    logic [RW-1:0] regs_out;

    spi_target #(.NUM_REGS(NREGS), .FRAME_BITS(40)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .sck_in(sck_in), .cs_n_in(cs_n_in),
        .serial_in(serial_in), .serial_out(serial_out), .serial_oe(serial_oe),
        .status_in(status_in), .frame_valid(frame_valid), .frame_write(frame_write),
        .frame_addr(frame_addr), .frame_data(frame_data), .frame_error(frame_error),
        .regs_out(regs_out)
    );

    always #20 clk_in = ~clk_in;

    typedef struct {
        bit          is_err;
        bit          wr;
        bit [6:0]    addr;
        bit [31:0]   data;
        bit          chk_miso;
        bit [39:0]   miso;
        bit [RW-1:0] regs;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_regs [NREGS];
    logic [31:0] model_pending;
    logic [39:0] last_rx;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [RW-1:0] pack_regs();
        logic [RW-1:0] p;
        for (int k = 0; k < NREGS; k++) p[k*32 +: 32] = model_regs[k];
        return p;
    endfunction

    // Mode-3 master: SCK idles high, MOSI set on fall, MISO captured on rise.
    // A non-negative reset_at asserts reset_in before that bit and abandons the frame.
    task automatic send_frame(input int nbits, input logic [39:0] word, input int reset_at);
        logic [39:0] rx;
        rx = '0;
        cs_n_in = 1'b0;
        repeat (HALF) @(negedge clk_in);
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                reset_in = 1'b1;
                @(negedge clk_in);
                chk("reset_oe", RW'(serial_oe), RW'(1'b0));
                chk("reset_regs", regs_out, '0);
                cs_n_in = 1'b1;
                sck_in  = 1'b1;
                repeat (6) @(negedge clk_in);
                reset_in = 1'b0;
                for (int k = 0; k < NREGS; k++) model_regs[k] = '0;
                model_pending = '0;
                repeat (GAP) @(negedge clk_in);
                return;
            end
            sck_in = 1'b0;
            serial_in = (i < 40) ? word[39-i] : 1'b0;
            repeat (HALF) @(negedge clk_in);
            sck_in = 1'b1;
            rx = {rx[38:0], serial_out};
            repeat (HALF) @(negedge clk_in);
        end
        last_rx = rx;
        cs_n_in = 1'b1;
        repeat (GAP) @(negedge clk_in);
    endtask

    task automatic do_frame(input bit wr, input bit [6:0] addr, input bit [31:0] data, input bit [7:0] st);
        exp_t e;
        status_in  = st;
        e.is_err   = 1'b0;
        e.wr       = wr;
        e.addr     = addr;
        e.data     = data;
        e.chk_miso = 1'b1;
        e.miso     = {st, model_pending};
        if (wr && addr < NREGS) model_regs[addr[2:0]] = data;
        model_pending = (addr < NREGS) ? model_regs[addr[2:0]] : 32'h0;
        e.regs = pack_regs();
        exp_q.push_back(e);
        send_frame(40, {wr, addr, data}, -1);
    endtask

    task automatic do_bad(input int nbits);
        exp_t e;
        e.is_err   = 1'b1;
        e.wr       = 1'b0;
        e.addr     = '0;
        e.data     = '0;
        e.chk_miso = 1'b0;
        e.miso     = '0;
        e.regs     = pack_regs();
        exp_q.push_back(e);
        send_frame(nbits, 40'hFF_1234_5678, -1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (frame_valid || frame_error) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got valid=%0b error=%0b required none", frame_valid, frame_error);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_error", RW'(frame_error), RW'(e.is_err));
                    chk("frame_valid", RW'(frame_valid), RW'(!e.is_err));
                    chk("regs_out", regs_out, e.regs);
                    if (!e.is_err) begin
                        chk("frame_write", RW'(frame_write), RW'(e.wr));
                        chk("frame_addr", RW'(frame_addr), RW'(e.addr));
                        chk("frame_data", RW'(frame_data), RW'(e.data));
                    end
                    if (e.chk_miso) chk("miso_word", RW'(last_rx), RW'(e.miso));
                    $display("txn %s wr=%0b addr=%0h data=%h miso=%h", e.is_err ? "error" : "valid",
                             frame_write, frame_addr, frame_data, last_rx);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL timeout: simulation exceeded time bound, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset_in  = 1'b1;
        sck_in    = 1'b1;
        cs_n_in   = 1'b1;
        serial_in = 1'b0;
        status_in = 8'h00;
        last_rx   = '0;
        model_pending = '0;
        for (int k = 0; k < NREGS; k++) model_regs[k] = '0;
        repeat (5) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        chk("rst_oe", RW'(serial_oe), RW'(1'b0));
        chk("rst_out", RW'(serial_out), RW'(1'b0));
        chk("rst_valid", RW'(frame_valid), RW'(1'b0));
        chk("rst_regs", regs_out, '0);
        repeat (4) @(negedge clk_in);

        do_frame(1'b1, 7'h02, 32'hDEADBEEF, 8'h11);   // first response is {status, 0}
        do_frame(1'b0, 7'h02, 32'h0,        8'hA5);
        do_frame(1'b0, 7'h02, 32'h0,        8'h3C);
        do_bad(20);                                   // short frame
        do_bad(0);                                    // CS pulse without clocks
        do_frame(1'b0, 7'h00, 32'h0,        8'h5A);   // pending survived the aborts
        do_frame(1'b1, 7'h05, 32'hCAFEF00D, 8'h01);
        do_frame(1'b1, 7'h7F, 32'h12345678, 8'h02);   // out-of-range write dropped
        do_frame(1'b0, 7'h05, 32'h0,        8'h03);   // response data 0 after 7F
        do_bad(41);                                   // too many clocks
        do_frame(1'b1, 7'h03, 32'h0BADF00D, 8'h04);
        send_frame(40, {1'b1, 7'h01, 32'h11112222}, 30);
        do_frame(1'b1, 7'h06, 32'h600D600D, 8'h77);   // post-reset response is {status, 0}
        do_frame(1'b0, 7'h06, 32'h0,        8'h88);
        do_frame(1'b0, 7'h03, 32'h0,        8'h99);

        repeat (20) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
